// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Shares one membus slave between the instruction-fetch master (m0) and the
//   data-access master (m1). Only one transaction is outstanding at a time.
//   Grant is round-robin on ties. Each response is routed back to the master
//   that issued the request.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   m0_* / m1_*                   master request (valid/ready/addr/wen/wdata/wmask)
//                                 and response (rvalid/rdata)
//   s_*                           slave request (valid/ready/addr/wen/wdata/wmask)
//                                 and response (rvalid/rdata)
//   dbg_state                     current FSM state (0 = IDLE, 1 = WAIT)
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high. Ready may depend on valid. The master must hold its request
// fields stable until then. A response is a single-cycle rvalid pulse with no
// backpressure.
module membus_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_wen,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [MASK_WIDTH-1:0] m0_wmask,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_wen,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [MASK_WIDTH-1:0] m1_wmask,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_wen,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [MASK_WIDTH-1:0] s_wmask,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   owner;  // master holding the outstanding request
  logic   last;   // last granted master

  logic any_valid;
  logic sel;      // selected master in IDLE
  logic accept;

  // A lone requester wins outright. On a tie the master not granted last time
  // wins. With last=0 after reset, m1 takes the first tie.
  assign any_valid = m0_valid | m1_valid;
  assign sel       = (m0_valid & m1_valid) ? ~last : m1_valid;
  assign accept    = (state == IDLE) & any_valid & s_ready;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner <= sel;
        last  <= sel;
      end
    end
  end

  always_comb begin
    state_next = state;
    s_valid    = 1'b0;
    s_addr     = '0;
    s_wen      = 1'b0;
    s_wdata    = '0;
    s_wmask    = '0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;

    case (state)
      IDLE: begin
        // A response arriving here has no owner and is dropped.
        if (any_valid) begin
          s_valid = 1'b1;
          if (sel) begin
            s_addr   = m1_addr;
            s_wen    = m1_wen;
            s_wdata  = m1_wdata;
            s_wmask  = m1_wmask;
            m1_ready = s_ready;
          end else begin
            s_addr   = m0_addr;
            s_wen    = m0_wen;
            s_wdata  = m0_wdata;
            s_wmask  = m0_wmask;
            m0_ready = s_ready;
          end
          if (s_ready) state_next = WAIT;
        end
      end
      WAIT: begin
        // The response passes straight through to the owner in the same cycle.
        if (s_rvalid) begin
          state_next = IDLE;
          if (owner) begin
            m1_rvalid = 1'b1;
            m1_rdata  = s_rdata;
          end else begin
            m0_rvalid = 1'b1;
            m0_rdata  = s_rdata;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_membus_arbiter.sv
module tb_membus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_valid, m0_ready, m0_wen, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [MW-1:0] m0_wmask;
  logic          m1_valid, m1_ready, m1_wen, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [MW-1:0] m1_wmask;
  logic          s_valid, s_ready, s_wen, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [MW-1:0] s_wmask;
  logic          dbg_state;

  membus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wen(m0_wen),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    m0_valid = 0; m0_addr = '0; m0_wen = 0; m0_wdata = '0; m0_wmask = '0;
    m1_valid = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
    s_ready = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // ---------------- table vectors (IDLE, last=0, no acceptance) ----------------
  typedef struct {
    string       name;
    logic        m0v, m1v, sr, rv;
    logic        exp_sv, exp_r0, exp_r1, exp_rv0, exp_rv1;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  // ---------------- reference model for random phase ----------------
  int ref_q[$];      // owners of outstanding requests (at most one)
  int ref_last;

  initial begin
    rst = 0;
    idle_inputs();

    // ---- reset state ----
    tick();
    rst = 1;
    settle();
    check("rst_dbg_state", dbg_state, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_s_wmask", s_wmask, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    tick();
    rst = 0;

    // ---- table-driven combinational vectors ----
    vecs[0] = '{"none",        0,0,0,0, 0,0,0,0,0, 64'h0};
    vecs[1] = '{"m0_only",     1,0,0,0, 1,0,0,0,0, 64'hA0};
    vecs[2] = '{"m1_only",     0,1,0,0, 1,0,0,0,0, 64'hB1};
    vecs[3] = '{"tie_m1",      1,1,0,0, 1,0,0,0,0, 64'hB1};
    vecs[4] = '{"stray_none",  0,0,1,1, 0,0,0,0,0, 64'h0};
    vecs[5] = '{"stray_m0",    1,0,0,1, 1,0,0,0,0, 64'hA0};
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      m0_addr = 64'hA0; m1_addr = 64'hB1;
      m0_valid = vecs[i].m0v; m1_valid = vecs[i].m1v;
      s_ready = vecs[i].sr; s_rvalid = vecs[i].rv; s_rdata = 64'h5555;
      settle();
      check({"vec_", vecs[i].name, "_s_valid"}, s_valid, vecs[i].exp_sv);
      check({"vec_", vecs[i].name, "_s_addr"}, s_addr, vecs[i].exp_addr);
      check({"vec_", vecs[i].name, "_m0_ready"}, m0_ready, vecs[i].exp_r0);
      check({"vec_", vecs[i].name, "_m1_ready"}, m1_ready, vecs[i].exp_r1);
      check({"vec_", vecs[i].name, "_m0_rvalid"}, m0_rvalid, vecs[i].exp_rv0);
      check({"vec_", vecs[i].name, "_m1_rvalid"}, m1_rvalid, vecs[i].exp_rv1);
      tick();
    end

    // ---- seq A: lone m1 read, 1-cycle slave ----
    do_reset();
    m1_valid = 1; m1_addr = 64'h0200_BFF8; s_ready = 1;
    settle();
    check("a_m1_ready", m1_ready, 1);
    check("a_s_valid", s_valid, 1);
    check("a_s_addr", s_addr, 64'h0200_BFF8);
    check("a_s_wen", s_wen, 0);
    check("a_m0_rvalid0", m0_rvalid, 0);
    tick();
    idle_inputs();
    s_rvalid = 1; s_rdata = 64'h1234;
    settle();
    check("a_m1_rvalid", m1_rvalid, 1);
    check("a_m1_rdata", m1_rdata, 64'h1234);
    check("a_m0_rvalid1", m0_rvalid, 0);
    check("a_s_valid_wait", s_valid, 0);
    tick();

    // ---- seq F: stray response in IDLE, then tie follows last (=m1) ----
    idle_inputs();
    s_rvalid = 1; s_rdata = 64'hDEAD;
    settle();
    check("f_stray_m0_rvalid", m0_rvalid, 0);
    check("f_stray_m1_rvalid", m1_rvalid, 0);
    check("f_stray_m1_rdata", m1_rdata, 0);
    tick();
    idle_inputs();
    m0_valid = 1; m1_valid = 1; m0_addr = 64'hC0; m1_addr = 64'hC1; s_ready = 1;
    settle();
    check("f_tie_m0_ready", m0_ready, 1);
    check("f_tie_m1_ready", m1_ready, 0);
    check("f_tie_s_addr", s_addr, 64'hC0);
    tick();
    idle_inputs();
    s_rvalid = 1; s_rdata = 64'h77;
    settle();
    check("f_resp_m0_rvalid", m0_rvalid, 1);
    tick();

    // ---- seq B: both continuously valid, alternating grants ----
    begin
      int resp_cnt = 0;
      int g = 0;
      do_reset();
      m0_valid = 1; m1_valid = 1; m0_addr = 64'h1000; m1_addr = 64'h2000; s_ready = 1;
      for (int c = 0; c < 8; c++) begin
        s_rvalid = 0; s_rdata = '0;
        if (c % 2 == 0) begin
          g = ((c / 2) % 2 == 0) ? 1 : 0;
          settle();
          check($sformatf("b_c%0d_m0_ready", c), m0_ready, (g == 0));
          check($sformatf("b_c%0d_m1_ready", c), m1_ready, (g == 1));
          check($sformatf("b_c%0d_s_addr", c), s_addr, (g == 1) ? 64'h2000 : 64'h1000);
        end else begin
          s_rvalid = 1; s_rdata = 64'hD0 + 64'(c);
          settle();
          check($sformatf("b_c%0d_s_valid", c), s_valid, 0);
          check($sformatf("b_c%0d_m0_rvalid", c), m0_rvalid, (g == 0));
          check($sformatf("b_c%0d_m1_rvalid", c), m1_rvalid, (g == 1));
          check($sformatf("b_c%0d_rdata", c), (g == 1) ? m1_rdata : m0_rdata, 64'hD0 + 64'(c));
          if (m0_rvalid | m1_rvalid) resp_cnt++;
        end
        tick();
      end
      check("b_resp_count", resp_cnt, 4);
    end

    // ---- seq C: m1 write under 3 cycles of backpressure ----
    idle_inputs();
    m1_valid = 1; m1_wen = 1; m1_addr = 64'h8000_0040; m1_wdata = 64'hFF; m1_wmask = 8'h01;
    for (int c = 0; c < 3; c++) begin
      s_ready = 0;
      settle();
      check($sformatf("c_c%0d_s_valid", c), s_valid, 1);
      check($sformatf("c_c%0d_s_addr", c), s_addr, 64'h8000_0040);
      check($sformatf("c_c%0d_s_wdata", c), s_wdata, 64'hFF);
      check($sformatf("c_c%0d_s_wmask", c), s_wmask, 64'h01);
      check($sformatf("c_c%0d_s_wen", c), s_wen, 1);
      check($sformatf("c_c%0d_m1_ready", c), m1_ready, 0);
      tick();
    end
    s_ready = 1;
    settle();
    check("c_accept_m1_ready", m1_ready, 1);
    tick();
    idle_inputs();
    s_rvalid = 1;
    settle();
    check("c_resp_m1_rvalid", m1_rvalid, 1);
    tick();

    // ---- seq D: slow slave, m0 keeps requesting during WAIT ----
    idle_inputs();
    m0_valid = 1; m0_addr = 64'h3000; s_ready = 1;
    settle();
    check("d_accept_m0_ready", m0_ready, 1);
    tick();
    for (int c = 0; c < 5; c++) begin
      s_rvalid = 0;
      settle();
      check($sformatf("d_w%0d_s_valid", c), s_valid, 0);
      check($sformatf("d_w%0d_m0_ready", c), m0_ready, 0);
      tick();
    end
    s_rvalid = 1; s_rdata = 64'hABCD;
    settle();
    check("d_resp_m0_rvalid", m0_rvalid, 1);
    check("d_resp_m0_rdata", m0_rdata, 64'hABCD);
    check("d_resp_m0_ready", m0_ready, 0);
    tick();
    s_rvalid = 0; s_rdata = '0;
    settle();
    check("d_regrant_m0_ready", m0_ready, 1);
    check("d_regrant_s_valid", s_valid, 1);
    tick();
    idle_inputs();
    s_rvalid = 1;
    settle();
    check("d_regrant_resp", m0_rvalid, 1);
    tick();

    // ---- seq E: reset during WAIT, late response dropped ----
    idle_inputs();
    m1_valid = 1; m1_addr = 64'h4000; s_ready = 1;
    settle();
    check("e_accept_m1_ready", m1_ready, 1);
    tick();
    idle_inputs();
    settle();
    check("e_in_wait", dbg_state, 1);
    rst = 1;
    settle();
    check("e_async_reset_state", dbg_state, 0);
    tick();
    rst = 0;
    tick();
    s_rvalid = 1; s_rdata = 64'hBAD;
    settle();
    check("e_late_m0_rvalid", m0_rvalid, 0);
    check("e_late_m1_rvalid", m1_rvalid, 0);
    check("e_late_state", dbg_state, 0);
    tick();

    // ---- random phase against queue-based reference model ----
    do_reset();
    ref_q.delete();
    ref_last = 0;
    for (int c = 0; c < 600; c++) begin
      int          sel;
      logic        e_sv, e_r0, e_r1, e_v0, e_v1;
      logic [63:0] e_addr, e_wdata, e_d0, e_d1;
      m0_valid = ($urandom_range(0, 2) != 0);
      m1_valid = ($urandom_range(0, 2) != 0);
      m0_addr  = {$urandom, $urandom}; m1_addr  = {$urandom, $urandom};
      m0_wdata = {$urandom, $urandom}; m1_wdata = {$urandom, $urandom};
      m0_wen   = 1'($urandom_range(0, 1)); m1_wen = 1'($urandom_range(0, 1));
      m0_wmask = 8'($urandom); m1_wmask = 8'($urandom);
      s_ready  = ($urandom_range(0, 1) == 1);
      s_rvalid = ($urandom_range(0, 1) == 1);
      s_rdata  = {$urandom, $urandom};
      settle();

      e_sv = 0; e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0;
      e_addr = '0; e_wdata = '0; e_d0 = '0; e_d1 = '0;
      if (ref_q.size() == 0) begin
        if (m0_valid || m1_valid) begin
          if (m0_valid && m1_valid) sel = 1 - ref_last;
          else                      sel = m1_valid ? 1 : 0;
          e_sv    = 1;
          e_addr  = (sel == 1) ? m1_addr : m0_addr;
          e_wdata = (sel == 1) ? m1_wdata : m0_wdata;
          if (sel == 1) e_r1 = s_ready; else e_r0 = s_ready;
          if (s_ready) begin
            ref_q.push_back(sel);
            ref_last = sel;
          end
        end
      end else if (s_rvalid) begin
        if (ref_q[0] == 1) begin e_v1 = 1; e_d1 = s_rdata; end
        else               begin e_v0 = 1; e_d0 = s_rdata; end
        void'(ref_q.pop_front());
      end

      check("rnd_s_valid", s_valid, e_sv);
      check("rnd_s_addr", s_addr, e_addr);
      check("rnd_s_wdata", s_wdata, e_wdata);
      check("rnd_m0_ready", m0_ready, e_r0);
      check("rnd_m1_ready", m1_ready, e_r1);
      check("rnd_m0_rvalid", m0_rvalid, e_v0);
      check("rnd_m1_rvalid", m1_rvalid, e_v1);
      check("rnd_m0_rdata", m0_rdata, e_d0);
      check("rnd_m1_rdata", m1_rdata, e_d1);
      tick();
    end

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Two-requester, one-target arbiter for the memory bus. It shares a single membus slave between the instruction-fetch port (m0) and the data-access port (m1).
- Sits between the core and the memory/MMIO side, for example the RAM and ACLINT address decoder.
- Allows one outstanding transaction at a time, uses round-robin grant, and routes each response back to the master that issued it.

Parameters:
- ADDR_WIDTH, 64, width of addr.
- DATA_WIDTH, 64, width of wdata/rdata.
- MASK_WIDTH, DATA_WIDTH/8, byte write-mask width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_valid  in  1  master0 request valid
- m0_ready  out  1  master0 request accepted this cycle
- m0_addr  in  ADDR_WIDTH  master0 address
- m0_wen  in  1  master0 write enable
- m0_wdata  in  DATA_WIDTH  master0 write data
- m0_wmask  in  MASK_WIDTH  master0 byte mask
- m0_rvalid  out  1  master0 response valid
- m0_rdata  out  DATA_WIDTH  master0 response data
- m1_valid, m1_ready, m1_addr, m1_wen, m1_wdata, m1_wmask, m1_rvalid, m1_rdata: same as m0_*, for master1
- s_valid  out  1  request to slave
- s_ready  in  1  slave accepts request
- s_addr  out  ADDR_WIDTH  forwarded address
- s_wen  out  1  forwarded write enable
- s_wdata  out  DATA_WIDTH  forwarded write data
- s_wmask  out  MASK_WIDTH  forwarded mask
- s_rvalid  in  1  slave response valid (asserted for reads and writes)
- s_rdata  in  DATA_WIDTH  slave response data

Behaviour:
- States: IDLE, WAIT. Registers:
  - state
  - owner (1 bit): master that holds the outstanding request
  - last (1 bit): last granted master
- Reset (rst=1, asynchronous): state=IDLE, owner=0, last=0.
  - Consequence: master1 has priority on the first tie after reset.
  - All outputs are combinational from state and inputs. With no inputs valid after reset, every valid/ready/rvalid output is 0 and every data output is 0.
- Grant selection in IDLE (combinational):
  - Only one master valid: that master is selected.
  - Both valid: select ~last (round-robin).
  - Neither valid: s_valid=0.
- IDLE forwarding:
  - s_valid = selected master's valid.
  - s_addr, s_wen, s_wdata and s_wmask come from the selected master. When nothing is selected they are driven 0.
  - sel_ready = s_ready gated to the selected master only. The non-selected master's ready=0.
- Acceptance = s_valid & s_ready in IDLE. At the next edge:
  - state=WAIT
  - owner=selected
  - last=selected
- Without acceptance the state stays IDLE and last is unchanged. Grant is re-evaluated every cycle, so a master may drop valid before acceptance.
- WAIT:
  - s_valid=0, m0_ready=0, m1_ready=0.
  - On s_rvalid=1: m<owner>_rvalid=1 and m<owner>_rdata=s_rdata in the same cycle (zero added latency). Next state is IDLE.
  - The other master's rvalid=0 and its rdata=0.
- s_rvalid in IDLE is a stray response: it is dropped, and neither m*_rvalid asserts.
- Throughput: at most one request per 2 cycles. A new grant happens no earlier than the cycle after the response.
- Latency: with a slave that asserts rvalid the cycle after acceptance, request accepted at cycle N gives the response at N+1, and the next grant is at N+2.
- Fairness: with both masters continuously valid, grants alternate 1,0,1,0,...
- Reset mid-transaction: WAIT is abandoned and state returns to IDLE. A late s_rvalid then arrives in IDLE and is dropped. The requester is expected to be reset by the same rst.
- Slave backpressure: s_ready=0 holds the request on s_* unchanged, provided the selected master keeps its signals stable.

Test Plan:
- Reset, then only m1 read addr=0x0200_BFF8 with s_ready=1 and rvalid one cycle later carrying rdata=0x1234 -> m1_ready=1 at cycle 0; m1_rvalid=1, m1_rdata=0x1234 at cycle 1; m0_rvalid=0 throughout.
- m0 and m1 both valid continuously for 8 cycles with a 1-cycle slave -> grant order m1,m0,m1,m0; 4 responses total, each routed to the correct master with distinct rdata.
- m1 write wdata=0xFF, wmask=0x01, with s_ready held 0 for 3 cycles -> s_valid=1 and s_addr/s_wdata/s_wmask stable for 3 cycles with m1_ready=0; acceptance in cycle 4.
- Slave response delayed 5 cycles in WAIT while m0 asserts valid -> s_valid=0 and m0_ready=0 for all 5 cycles; m0 granted in the cycle after the response.
- Assert rst while in WAIT, then s_rvalid=1 one cycle after rst deasserts -> both m*_rvalid stay 0; state=IDLE.
- Stray s_rvalid in IDLE with no request outstanding -> dropped; next tie grants per last.
